// File: rtl/bank_stream_reader.sv
// rtl/bank_stream_reader.sv - block-read stream master over one bank RAM slot; BANK_STREAM_INTERLEAVE_EN stripes words across banks
module bank_stream_reader #(
    parameter int NUM_BANKS      = 5,
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 12,
    parameter int OUT_FIFO_DEPTH = 4,
    parameter int BANK_W         = $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [BANK_W-1:0]     start_bank,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  start_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_we,
    output logic [BANK_W-1:0]     cmd_bank,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_V = (PTR_W + 2)'(OUT_FIFO_DEPTH);
    localparam logic [BANK_W:0]  NB_V    = (BANK_W + 1)'(NUM_BANKS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]            state, state_nxt;
    logic                  ready_r, err_r;
    logic [LEN_WIDTH-1:0]  len_r, issued, delivered;
    logic [BANK_W-1:0]     bank_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [PTR_W:0]        outstanding, wptr, rptr, fifo_count;
    logic [PTR_W+1:0]      in_flight;
    logic [DATA_WIDTH-1:0] mem [OUT_FIFO_DEPTH];

    logic start_fire, bad_bank, credit, cmd_fire, push, pop, last_cmd, drain_done;

    assign start_fire = start_valid && ready_r;
    assign bad_bank   = {1'b0, start_bank} >= NB_V;
    assign fifo_count = wptr - rptr;
    // Responses move words from outstanding into the FIFO, so this sum bounds both.
    assign in_flight  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit     = in_flight < DEPTH_V;
    assign cmd_valid  = (state == S_ISSUE) && credit;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign push       = rsp_valid && (outstanding != '0);
    assign out_valid  = fifo_count != '0;
    assign pop        = out_valid && out_ready;
    assign last_cmd   = issued == (len_r - 1'b1);
    assign drain_done = (delivered + {{(LEN_WIDTH-1){1'b0}}, pop}) == len_r;

    assign start_ready = ready_r;
    assign busy        = state != S_IDLE;
    assign done        = state == S_FINISH;
    assign err         = done && err_r;
    assign cmd_we      = 1'b0;
    assign cmd_bank    = bank_r;
    assign cmd_addr    = addr_r;
    assign out_data    = out_valid ? mem[rptr[PTR_W-1:0]] : '0;
    assign out_last    = out_valid && (delivered == (len_r - 1'b1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_fire)
                    state_nxt = ((start_len == '0) || bad_bank) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                if (cmd_fire && last_cmd)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done)
                    state_nxt = S_FINISH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            ready_r     <= 1'b0;
            err_r       <= 1'b0;
            len_r       <= '0;
            issued      <= '0;
            delivered   <= '0;
            bank_r      <= '0;
            addr_r      <= '0;
            outstanding <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            state   <= state_nxt;
            ready_r <= state_nxt == S_IDLE;

            if (start_fire) begin
                err_r     <= bad_bank;
                len_r     <= start_len;
                bank_r    <= start_bank;
                addr_r    <= start_addr;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (cmd_fire) begin
                    issued <= issued + 1'b1;
`ifdef BANK_STREAM_INTERLEAVE_EN
                    if (bank_r == BANK_W'(NUM_BANKS - 1)) begin
                        bank_r <= '0;
                        addr_r <= addr_r + 1'b1;
                    end else begin
                        bank_r <= bank_r + 1'b1;
                    end
`else
                    addr_r <= addr_r + 1'b1;
`endif
                end
                if (pop)
                    delivered <= delivered + 1'b1;
            end

            case ({cmd_fire, push})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[PTR_W-1:0]] <= rsp_data;
    end
endmodule

// File: tb/tb_bank_stream_reader.sv
// tb/tb_bank_stream_reader.sv - table-driven and randomized bench for bank_stream_reader
`timescale 1ns/1ps
module tb_bank_stream_reader;
    localparam int NB = 5, AW = 9, DW = 32, LW = 12, DEPTH = 4, BW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_valid, start_ready, busy, done, err;
    logic [BW-1:0] start_bank, cmd_bank;
    logic [AW-1:0] start_addr, cmd_addr;
    logic [LW-1:0] start_len;
    logic cmd_valid, cmd_ready, cmd_we, rsp_valid, out_valid, out_ready, out_last;
    logic [DW-1:0] rsp_data, out_data;

    always #5 clk = ~clk;

    bank_stream_reader dut (
        .clk(clk), .rstn(rstn),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_bank(start_bank), .start_addr(start_addr), .start_len(start_len),
        .busy(busy), .done(done), .err(err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    typedef struct {
        logic [BW-1:0] bank;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            cmode;
        int            omode;
        logic          exp_err;
        int            exp_ncmd;
    } vec_t;
    typedef struct { logic [BW-1:0] bank; logic [AW-1:0] addr; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic last; } out_t;
    typedef struct { int due; logic [DW-1:0] data; } rsp_t;

    cmd_t cmd_log[$];
    out_t out_log[$];
    rsp_t pend[$];
    int   cmode = 0, omode = 0, stale_req = 0, stale_seen = 0;
    int   done_cnt = 0, bcyc = 0, last_due = 0;
    time  done_time = 0, last_out_time = 0;
    logic done_err = 1'b0;
    int   total = 0, bad = 0;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ram(input logic [BW-1:0] b, input logic [AW-1:0] a);
        logic [DW-1:0] k;
        k = {20'h0, b, a};
        return (k * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Word i of a request, computed directly from its linear position.
    function automatic cmd_t model_cmd(input logic [BW-1:0] b, input logic [AW-1:0] a, input int i);
        cmd_t m;
`ifdef BANK_STREAM_INTERLEAVE_EN
        int idx;
        idx    = int'(b) + i;
        m.bank = BW'(idx % NB);
        m.addr = AW'(int'(a) + idx / NB);
`else
        m.bank = b;
        m.addr = AW'(int'(a) + i);
`endif
        return m;
    endfunction

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ctl"}, {start_ready, busy, done, err, cmd_valid, cmd_we, out_valid, out_last}, 8'h0);
        chk({nm, "_cmd"}, {cmd_bank, cmd_addr}, 0);
        chk({nm, "_data"}, out_data, 0);
    endtask

    // RAM slot, consumer and monitor: drive at negedge, log handshakes completing at next posedge.
    initial begin
        logic prev_stall;
        cmd_t prev_cmd, c;
        out_t o;
        rsp_t r;
        prev_stall = 1'b0;
        prev_cmd   = '{0, 0};
        cmd_ready = 1'b0; out_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        forever begin
            @(negedge clk);
            bcyc++;
            if (!rstn) begin
                pend.delete();
                last_due = 0;
                prev_stall = 1'b0;
                cmd_ready = 1'b0; out_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
            end else begin
                case (cmode)
                    0:       cmd_ready = 1'b1;
                    1:       cmd_ready = 1'($urandom_range(0, 1));
                    default: cmd_ready = (bcyc % 7) >= 5;
                endcase
                case (omode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = $urandom_range(0, 3) != 0;
                    default: out_ready = 1'b0;
                endcase
                if (stale_seen != stale_req) begin
                    stale_seen = stale_req;
                    rsp_valid = 1'b1; rsp_data = 32'hDEADBEEF;
                end else if (pend.size() > 0 && pend[0].due <= bcyc) begin
                    rsp_valid = 1'b1; rsp_data = pend[0].data;
                    pend.delete(0);
                end else begin
                    rsp_valid = 1'b0; rsp_data = '0;
                end
                if (prev_stall)
                    chk("cmd_hold", {cmd_valid, cmd_bank, cmd_addr}, {1'b1, prev_cmd.bank, prev_cmd.addr});
                if (cmd_valid)
                    chk("credit", (cmd_log.size() - out_log.size()) < DEPTH, 1);
                if (cmd_valid && cmd_ready) begin
                    c.bank = cmd_bank; c.addr = cmd_addr;
                    cmd_log.push_back(c);
                    r.due = bcyc + $urandom_range(1, 3);
                    if (r.due <= last_due) r.due = last_due + 1;
                    last_due = r.due;
                    r.data = ram(cmd_bank, cmd_addr);
                    pend.push_back(r);
                end
                prev_stall = cmd_valid && !cmd_ready;
                prev_cmd.bank = cmd_bank; prev_cmd.addr = cmd_addr;
                if (out_valid && out_ready) begin
                    o.data = out_data; o.last = out_last;
                    out_log.push_back(o);
                    last_out_time = $time;
                end
                if (done) begin
                    done_cnt++; done_time = $time; done_err = err;
                end
            end
        end
    end

    task automatic run_req(input vec_t v);
        int old;
        bit got;
        time tacc, exp_t;
        cmd_t m;
        cmd_log.delete(); out_log.delete();
        cmode = v.cmode; omode = v.omode;
        old = done_cnt; got = 0; tacc = 0;
        @(negedge clk);
        start_valid = 1'b1; start_bank = v.bank; start_addr = v.addr; start_len = v.len;
        for (int i = 0; i < 50 && !got; i++) begin
            if (start_ready) begin got = 1; tacc = $time; end
            else @(negedge clk);
        end
        chk("start_accept", got, 1);
        @(negedge clk);
        start_valid = 1'b0;
        if (v.omode == 2) begin
            repeat (30) @(negedge clk);
            #2;
            chk("bp_cmds", cmd_log.size(), DEPTH);
            chk("bp_cmd_valid", cmd_valid, 0);
            chk("bp_out_valid", out_valid, 1);
            omode = 0;
        end
        for (int i = 0; i < 3000 && done_cnt == old; i++) @(negedge clk);
        #2;
        chk("done_seen", done_cnt != old, 1);
        chk("err", done_err, v.exp_err);
        chk("ncmd", cmd_log.size(), v.exp_ncmd);
        chk("nout", out_log.size(), v.exp_ncmd);
        exp_t = (v.exp_ncmd == 0) ? tacc + 10 : last_out_time + 10;
        chk("done_time", done_time, exp_t);
        for (int i = 0; i < v.exp_ncmd && i < cmd_log.size() && i < out_log.size(); i++) begin
            m = model_cmd(v.bank, v.addr, i);
            chk("cmd", {cmd_log[i].bank, cmd_log[i].addr}, {m.bank, m.addr});
            chk("data", out_log[i].data, ram(m.bank, m.addr));
            chk("last", out_log[i].last, i == v.exp_ncmd - 1);
        end
        @(negedge clk);
        #2;
        chk("idle_after", {busy, start_ready, done}, 3'b010);
    endtask

    initial begin
        logic [AW+BW-1:0] g;
        vec_t v;
        bit seen;
        //          bank  addr    len    cm om err n
        tbl[0] = '{3'd2, 9'h010, 12'd3,  0, 0, 1'b0, 3};
        tbl[1] = '{3'd0, 9'h100, 12'd8,  2, 0, 1'b0, 8};
        tbl[2] = '{3'd3, 9'h020, 12'd10, 0, 2, 1'b0, 10};
        tbl[3] = '{3'd1, 9'h000, 12'd0,  0, 0, 1'b0, 0};
        tbl[4] = '{3'd7, 9'h055, 12'd4,  0, 0, 1'b1, 0};
        tbl[5] = '{3'd5, 9'h000, 12'd0,  0, 0, 1'b1, 0};
        tbl[6] = '{3'd1, 9'h1FF, 12'd2,  1, 1, 1'b0, 2};
        tbl[7] = '{3'd4, 9'h005, 12'd3,  0, 1, 1'b0, 3};
        tbl[8] = '{3'd4, 9'h1FE, 12'd12, 1, 1, 1'b0, 12};
        tbl[9] = '{3'd0, 9'h000, 12'd1,  0, 0, 1'b0, 1};

        start_valid = 1'b0; start_bank = '0; start_addr = '0; start_len = '0;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", start_ready, 1);

        for (int i = 0; i < 10; i++) begin
            run_req(tbl[i]);
`ifdef BANK_STREAM_INTERLEAVE_EN
            if (i == 7) begin
                g = (cmd_log.size() > 2) ? {cmd_log[1].bank, cmd_log[1].addr} : '1;
                chk("stripe_cmd1", g, {3'd0, 9'h006});
                g = (cmd_log.size() > 2) ? {cmd_log[2].bank, cmd_log[2].addr} : '1;
                chk("stripe_cmd2", g, {3'd1, 9'h006});
            end
`else
            if (i == 6) begin
                g = (cmd_log.size() > 1) ? {cmd_log[1].bank, cmd_log[1].addr} : '1;
                chk("addr_wrap", g, {3'd1, 9'h000});
            end
`endif
        end

        // Reset in the middle of a request, then a stale response.
        cmd_log.delete(); out_log.delete();
        cmode = 0; omode = 2;
        @(negedge clk);
        start_valid = 1'b1; start_bank = 3'd2; start_addr = 9'h040; start_len = 12'd6;
        @(negedge clk);
        start_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = cmd_log.size() >= 2;
        end
        chk("mid_two_cmds", cmd_log.size(), 2);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        stale_req++;
        repeat (5) @(negedge clk);
        #2;
        chk("stale_ignored", {out_valid, busy, cmd_valid}, 3'b000);
        chk("ready_after_mid_reset", start_ready, 1);
        run_req('{3'd2, 9'h0F0, 12'd6, 0, 0, 1'b0, 6});

        for (int r = 0; r < 12; r++) begin
            v.bank     = ($urandom_range(0, 5) == 0) ? BW'($urandom_range(5, 7)) : BW'($urandom_range(0, 4));
            v.addr     = AW'($urandom);
            v.len      = LW'($urandom_range(0, 20));
            v.cmode    = $urandom_range(0, 2);
            v.omode    = $urandom_range(0, 1);
            v.exp_err  = int'(v.bank) >= NB;
            v.exp_ncmd = v.exp_err ? 0 : int'(v.len);
            run_req(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
